// File: rtl/avmm_pio_responder.sv
// Avalon-MM PIO responder: a writable parallel output register, a synchronized
// parallel input with edge capture, and a level interrupt for enabled edges.
// Register map (word offsets):
//   0 DATA    : read synchronized input, write output register
//   1 OUTREG  : read output register, write output register
//   2 IRQMASK : interrupt enable per input bit
//   3 EDGECAP : captured edges, write-one-to-clear
module avmm_pio_responder #(
    parameter int                   OUT_WIDTH = 7,
    parameter int                   IN_WIDTH  = 4,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET = OUT_WIDTH'(7'h7f),
    parameter int                   EDGE_MODE = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [1:0]           avs_address,
    input  logic                 avs_chipselect,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 irq,
    output logic [OUT_WIDTH-1:0] pio_out,
    input  logic [IN_WIDTH-1:0]  pio_in
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_OUTREG  = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Architectural state
    logic [OUT_WIDTH-1:0] out_reg;
    logic [IN_WIDTH-1:0]  irqmask_reg;
    logic [IN_WIDTH-1:0]  edgecap_reg;
    logic [31:0]          readdata_reg;

    // Input synchronizer chain and the delayed copy used for edge detection
    logic [IN_WIDTH-1:0]  s1_reg;
    logic [IN_WIDTH-1:0]  s2_reg;
    logic [IN_WIDTH-1:0]  prev_reg;

    // Next-state values
    logic [OUT_WIDTH-1:0] out_next;
    logic [IN_WIDTH-1:0]  irqmask_next;
    logic [IN_WIDTH-1:0]  edgecap_next;
    logic [31:0]          readdata_next;

    // Decoded bus activity
    logic                 accept_rd;
    logic                 accept_wr;
    logic                 wr_out;
    logic                 wr_mask;
    logic                 wr_cap;
    logic [IN_WIDTH-1:0]  cap_clear;
    logic [IN_WIDTH-1:0]  edge_det;

    // Upper write-data bits beyond the register widths are intentionally ignored
    logic                 unused_wdata;
    assign unused_wdata = ^avs_writedata;

    // No waitrequest: every selected strobe is accepted in the cycle it appears
    assign accept_rd = avs_chipselect & avs_read;
    assign accept_wr = avs_chipselect & avs_write;

    // Offsets 0 and 1 both load the output register
    assign wr_out  = accept_wr && ((avs_address == ADDR_DATA) || (avs_address == ADDR_OUTREG));
    assign wr_mask = accept_wr && (avs_address == ADDR_IRQMASK);
    assign wr_cap  = accept_wr && (avs_address == ADDR_EDGECAP);

    assign cap_clear = wr_cap ? avs_writedata[IN_WIDTH-1:0] : '0;

    // Per-bit edge detector; EDGE_MODE picks rising, falling or either edge
    generate
        for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_edge
            if (EDGE_MODE == 0) begin : g_rise
                assign edge_det[gi] = s2_reg[gi] & ~prev_reg[gi];
            end else if (EDGE_MODE == 1) begin : g_fall
                assign edge_det[gi] = ~s2_reg[gi] & prev_reg[gi];
            end else begin : g_any
                assign edge_det[gi] = s2_reg[gi] ^ prev_reg[gi];
            end
        end
    endgenerate

    // Output register next value
    always_comb begin
        out_next = out_reg;
        if (wr_out) begin
            out_next = avs_writedata[OUT_WIDTH-1:0];
        end
    end

    // Interrupt mask next value
    always_comb begin
        irqmask_next = irqmask_reg;
        if (wr_mask) begin
            irqmask_next = avs_writedata[IN_WIDTH-1:0];
        end
    end

    // Edge capture: a new edge is OR-ed in after the clear, so it wins a collision
    always_comb begin
        edgecap_next = (edgecap_reg & ~cap_clear) | edge_det;
    end

    // Read mux uses current (pre-write) register values
    always_comb begin
        readdata_next = readdata_reg;
        if (accept_rd) begin
            case (avs_address)
                ADDR_DATA:    readdata_next = 32'(s2_reg);
                ADDR_OUTREG:  readdata_next = 32'(out_reg);
                ADDR_IRQMASK: readdata_next = 32'(irqmask_reg);
                ADDR_EDGECAP: readdata_next = 32'(edgecap_reg);
                default:      readdata_next = '0;
            endcase
        end
    end

    // Synchronizer: reset loads the live input into all stages to avoid a false edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_reg   <= pio_in;
            s2_reg   <= pio_in;
            prev_reg <= pio_in;
        end else begin
            s1_reg   <= pio_in;
            s2_reg   <= s1_reg;
            prev_reg <= s2_reg;
        end
    end

    // Control/status registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_reg     <= OUT_RESET;
            irqmask_reg <= '0;
            edgecap_reg <= '0;
        end else begin
            out_reg     <= out_next;
            irqmask_reg <= irqmask_next;
            edgecap_reg <= edgecap_next;
        end
    end

    // Registered read data, one cycle latency, held between reads
    always_ff @(posedge CLK) begin
        if (RST) begin
            readdata_reg <= '0;
        end else begin
            readdata_reg <= readdata_next;
        end
    end

    assign avs_readdata = readdata_reg;
    assign pio_out      = out_reg;
    assign irq          = |(edgecap_reg & irqmask_reg);

endmodule

// File: tb/tb_avmm_pio_responder.sv
// Bench for avmm_pio_responder: two instances (falling-edge and any-edge capture)
// share one bus and one input vector. A register-level model predicts every
// output each cycle; directed steps add hand-computed literal checks.
module tb_avmm_pio_responder;

    logic        clk;
    logic        rst;
    logic [1:0]  addr;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  pin;

    logic [31:0] rdata0, rdata1;
    logic        irq0, irq1;
    logic [6:0]  out0, out1;

    int tests;
    int failed;

    avmm_pio_responder #(.OUT_WIDTH(7), .IN_WIDTH(4), .OUT_RESET(7'h7f), .EDGE_MODE(1)) dut_fall (
        .CLK(clk), .RST(rst), .avs_address(addr), .avs_chipselect(cs), .avs_read(rd),
        .avs_write(wr), .avs_writedata(wd), .avs_readdata(rdata0), .irq(irq0),
        .pio_out(out0), .pio_in(pin)
    );

    avmm_pio_responder #(.OUT_WIDTH(7), .IN_WIDTH(4), .OUT_RESET(7'h7f), .EDGE_MODE(2)) dut_any (
        .CLK(clk), .RST(rst), .avs_address(addr), .avs_chipselect(cs), .avs_read(rd),
        .avs_write(wr), .avs_writedata(wd), .avs_readdata(rdata1), .irq(irq1),
        .pio_out(out1), .pio_in(pin)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // hist_q[k] is the input value sampled k+1 edges ago; the design sees the
    // input two edges late and compares it with the value one edge older still.
    logic [6:0]  m_out  [2];
    logic [3:0]  m_mask [2];
    logic [3:0]  m_cap  [2];
    logic [31:0] m_rd   [2];
    logic [3:0]  hist_q [3];
    logic        m_valid = 1'b0;

    function automatic logic [3:0] edges_of(int mode, logic [3:0] now_v, logic [3:0] old_v);
        if (mode == 0) return now_v & ~old_v;
        if (mode == 1) return ~now_v & old_v;
        return now_v ^ old_v;
    endfunction

    function automatic logic [31:0] read_value(int i, logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, hist_q[1]};
            2'd1:    return {25'd0, m_out[i]};
            2'd2:    return {28'd0, m_mask[i]};
            default: return {28'd0, m_cap[i]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_out[i]  <= 7'h7f;
                m_mask[i] <= 4'h0;
                m_cap[i]  <= 4'h0;
                m_rd[i]   <= 32'h0;
            end
            for (int k = 0; k < 3; k++) hist_q[k] <= pin;
            m_valid <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (cs && rd) m_rd[i] <= read_value(i, addr);
                m_cap[i] <= (m_cap[i] & ~((cs && wr && addr == 2'd3) ? wd[3:0] : 4'h0))
                            | edges_of((i == 0) ? 1 : 2, hist_q[1], hist_q[2]);
                if (cs && wr && addr <= 2'd1) m_out[i]  <= wd[6:0];
                if (cs && wr && addr == 2'd2) m_mask[i] <= wd[3:0];
            end
            hist_q[0] <= pin;
            hist_q[1] <= hist_q[0];
            hist_q[2] <= hist_q[1];
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("m_out0",  {25'd0, out0}, {25'd0, m_out[0]});
            check("m_irq0",  {31'd0, irq0}, {31'd0, |(m_cap[0] & m_mask[0])});
            check("m_rd0",   rdata0, m_rd[0]);
            check("m_out1",  {25'd0, out1}, {25'd0, m_out[1]});
            check("m_irq1",  {31'd0, irq1}, {31'd0, |(m_cap[1] & m_mask[1])});
            check("m_rd1",   rdata1, m_rd[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_write(logic [1:0] a, logic [31:0] d);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; wd = d;
        step(1);
        idle();
    endtask

    task automatic bus_read(logic [1:0] a, output logic [31:0] r0, output logic [31:0] r1);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        step(1);
        r0 = rdata0;
        r1 = rdata1;
        idle();
    endtask

    logic [31:0] r0, r1;

    initial begin
        tests = 0; failed = 0;
        rst = 1'b1; pin = 4'hF; addr = 2'd0; wd = 32'h0;
        idle();
        step(3);
        rst = 1'b0;
        $display("[TB] reset released");
        check("rst_out", {25'd0, out0}, 32'h7f);
        check("rst_irq", {31'd0, irq0}, 32'h0);
        check("rst_rd",  rdata0, 32'h0);
        step(5);
        bus_read(2'd3, r0, r1);
        check("rst_cap0", r0, 32'h0);
        check("rst_cap1", r1, 32'h0);

        bus_write(2'd0, 32'h40);
        $display("[TB] write DATA 0x40");
        check("wr_out", {25'd0, out0}, 32'h40);
        bus_read(2'd1, r0, r1);
        $display("[TB] read OUTREG -> %h", r0);
        check("rd_outreg", r0, 32'h40);

        bus_write(2'd2, 32'h1);
        pin = 4'hE;
        step(2);
        check("lat_e2_irq", {31'd0, irq0}, 32'h0);
        step(1);
        $display("[TB] bit0 falling edge captured");
        check("lat_e3_irq0", {31'd0, irq0}, 32'h1);
        check("lat_e3_irq1", {31'd0, irq1}, 32'h1);
        bus_read(2'd3, r0, r1);
        check("cap_bit0", r0, 32'h1);
        bus_write(2'd3, 32'h1);
        $display("[TB] clear EDGECAP bit0");
        check("clr_irq0", {31'd0, irq0}, 32'h0);

        bus_write(2'd2, 32'h0);
        pin = 4'hA;
        step(4);
        check("mask0_irq", {31'd0, irq0}, 32'h0);
        bus_read(2'd0, r0, r1);
        $display("[TB] read DATA -> %h", r0);
        check("rd_data", r0, 32'hA);
        bus_read(2'd3, r0, r1);
        check("mask0_cap0", r0, 32'h4);
        check("mask0_cap1", r1, 32'h4);

        bus_write(2'd2, 32'h4);
        pin = 4'hE;
        step(3);
        pin = 4'hA;
        step(2);
        bus_write(2'd3, 32'h4);
        $display("[TB] clear collides with new bit2 edge");
        check("coll_irq0", {31'd0, irq0}, 32'h1);
        check("coll_irq1", {31'd0, irq1}, 32'h1);
        bus_read(2'd3, r0, r1);
        check("coll_cap0", r0, 32'h4);
        bus_write(2'd3, 32'h4);
        check("coll_clr_irq0", {31'd0, irq0}, 32'h0);

        bus_write(2'd2, 32'h8);
        pin = 4'h2;
        step(4);
        bus_write(2'd3, 32'hF);
        pin = 4'hA;
        step(3);
        pin = 4'h2;
        bus_read(2'd3, r0, r1);
        $display("[TB] bit3 pulse rise: cap0=%h cap1=%h", r0, r1);
        check("pulse_rise_cap0", r0, 32'h0);
        check("pulse_rise_cap1", r1, 32'h8);
        bus_write(2'd3, 32'h8);
        check("pulse_clr_irq1", {31'd0, irq1}, 32'h0);
        step(1);
        check("pulse_fall_irq0", {31'd0, irq0}, 32'h1);
        check("pulse_fall_irq1", {31'd0, irq1}, 32'h1);
        bus_read(2'd3, r0, r1);
        check("pulse_fall_cap0", r0, 32'h8);
        check("pulse_fall_cap1", r1, 32'h8);

        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 2'd1; wd = 32'h15;
        step(1);
        idle();
        $display("[TB] simultaneous read/write OUTREG -> %h", rdata0);
        check("rw_rd", rdata0, 32'h40);
        check("rw_out", {25'd0, out0}, 32'h15);

        cs = 1'b0; wr = 1'b1; addr = 2'd0; wd = 32'h7;
        step(1);
        idle();
        check("cs_low_out", {25'd0, out0}, 32'h15);

        cs = 1'b1; rd = 1'b1; addr = 2'd1; rst = 1'b1;
        step(1);
        idle();
        rst = 1'b0;
        $display("[TB] read aborted by reset -> %h", rdata0);
        check("rst_read_rd", rdata0, 32'h0);
        check("rst_read_out", {25'd0, out0}, 32'h7f);
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/avmm_pio_responder.md
Name: avmm_pio_responder

Overview:
- Avalon-MM slave PIO peripheral: the responder end of the Nios II data-master bus, instantiated inside the Platform Designer system.
- Drives a parallel output port, e.g. a 7-segment HEX digit with active-low segments.
- Samples a parallel input port (slide switches or push keys), synchronizes it to CLK and captures edges.
- Raises a level interrupt to the CPU on enabled captured edges.

Parameters:
- OUT_WIDTH, 7, width of pio_out (1..32).
- IN_WIDTH, 4, width of pio_in (1..32).
- OUT_RESET, 7'h7f, reset value of the output register (all segments dark).
- EDGE_MODE, 1, edge type captured: 0 = rising, 1 = falling, 2 = any.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- avs_address  in  2  word offset of the register.
- avs_chipselect  in  1  slave select; read and write are ignored when low.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data; fixed read latency of 1.
- irq  out  1  level interrupt to the CPU.
- pio_out  out  OUT_WIDTH  output register contents.
- pio_in  in  IN_WIDTH  asynchronous external inputs.

Behaviour:
- Bus protocol:
  - No waitrequest. A transaction is accepted in every cycle where chipselect is high together with read or write.
  - avs_readdata is registered. It updates on the edge that ends an accepted read, so it is valid in the next cycle, and holds its value otherwise.
  - Unused upper bits read as 0.
- Register map:
  - Offset 0, DATA. Read returns the synchronized input s2, zero-extended. Write loads writedata[OUT_WIDTH-1:0] into the output register.
  - Offset 1, OUTREG. Read returns the output register, zero-extended. Write behaves as a write to offset 0.
  - Offset 2, IRQMASK. Read/write, IN_WIDTH bits.
  - Offset 3, EDGECAP. Read returns the captured edges. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- Input path:
  - Two-flop synchronizer s1 -> s2, plus a delayed copy prev of s2.
  - Edge detect is combinational: rising = s2 & ~prev; falling = ~s2 & prev; any = s2 ^ prev. EDGE_MODE selects which one is used.
  - A detected edge sets its EDGECAP bit on the next edge.
  - Latency: a pio_in change that meets setup before edge E1 is
    - visible in s2 after E2,
    - set in EDGECAP after E3,
    - reflected on irq after E3.
- irq = |(EDGECAP & IRQMASK). It is combinational from registers only.
- pio_out is the output register directly; a write becomes visible on pio_out after the accepting edge.
- Simultaneous events:
  - Clear and new edge on the same EDGECAP bit in the same cycle: the set wins and the bit stays 1.
  - Read and write to the same offset in the same cycle: readdata returns the pre-write value.
  - A write with chipselect low has no effect.
- Reset (synchronous):
  - Output register = OUT_RESET; IRQMASK = 0; EDGECAP = 0; avs_readdata = 0.
  - s1, s2 and prev all load pio_in directly, so releasing reset never produces a spurious edge.
  - Asserting RST mid-transaction aborts it. A read accepted in the reset cycle returns 0 in the following cycle.

Test Plan:
- Reset with pio_in=4'hF -> pio_out=7'h7f, irq=0, EDGECAP reads 0, no edge captured in the 5 cycles after release.
- Write 32'h40 to offset 0 -> pio_out=7'h40 the cycle after acceptance; read offset 1 -> readdata=32'h40 exactly 1 cycle after the read strobe.
- EDGE_MODE=1, IRQMASK=4'h1, pio_in bit0 1->0 -> EDGECAP=4'h1 and irq=1 three edges after the change. Write 4'h1 to offset 3 -> irq=0 next cycle.
- pio_in=4'hA held stable -> read offset 0 returns 32'h0000000A. IRQMASK=0 with an edge captured -> EDGECAP bit set, irq stays 0.
- Clear write to EDGECAP bit2 in the same cycle a new bit2 edge is detected -> bit2 remains 1 and irq stays high.
- EDGE_MODE=2, pulse pio_in bit3 high for 3 cycles -> EDGECAP bit3 set; after a clear, the falling edge sets it again.
